// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath: default widths, a lane extraction
// helper for flat complex buses, and the round-half-up halving used for block scaling.
package fft_pkg;

  localparam int N_DEF     = 16;
  localparam int LANES_DEF = 16;

  // Helpers work on generously sized containers; callers extend into and truncate out of them.
  localparam int MAX_BUS = 4096;
  localparam int MAX_W   = 64;

  // Lane k of an n-bit-per-lane flat bus, zero-extended to MAX_W bits.
  function automatic logic [MAX_W-1:0] lane_slice(input logic [MAX_BUS-1:0] bus,
                                                  input int k, input int n);
    logic [MAX_BUS-1:0] sh;
    sh = bus >> (k * n);
    return sh[MAX_W-1:0] & ({MAX_W{1'b1}} >> (MAX_W - n));
  endfunction

  // (x + 1) >>> 1; the wide container means the +1 can never overflow.
  function automatic logic signed [MAX_W-1:0] round_half_up(input logic signed [MAX_W-1:0] x);
    return (x + MAX_W'(1)) >>> 1;
  endfunction

endpackage

// File: rtl/fft_lane_scale.sv
// Per-lane optional divide-by-2 with round-half-up on both components of each
// complex sample; purely combinational.
module fft_lane_scale
  import fft_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int LANES = LANES_DEF
) (
  input  logic                 scale,
  input  logic [LANES*N-1:0]   in_r,
  input  logic [LANES*N-1:0]   in_i,
  output logic [LANES*N-1:0]   out_r,
  output logic [LANES*N-1:0]   out_i
);

  logic [MAX_BUS-1:0] bus_r;
  logic [MAX_BUS-1:0] bus_i;

  assign bus_r = MAX_BUS'(in_r);
  assign bus_i = MAX_BUS'(in_i);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [N-1:0] xr;
    logic signed [N-1:0] xi;

    assign xr = N'(lane_slice(bus_r, k, N));
    assign xi = N'(lane_slice(bus_i, k, N));

    // Sign-extend into the wide container, halve, then truncate back to N bits.
    assign out_r[k*N +: N] = scale ? N'(round_half_up(MAX_W'(xr))) : xr;
    assign out_i[k*N +: N] = scale ? N'(round_half_up(MAX_W'(xi))) : xi;
  end

endmodule

// File: rtl/fft_pipe_stage_elastic.sv
// Elastic register stage between FFT butterfly ranks: DEPTH-entry circular
// buffer with valid/ready handshake, optional per-beat halving applied on push.
module fft_pipe_stage_elastic
  import fft_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int LANES = LANES_DEF,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_scale,
  input  logic [LANES*N-1:0]           in_r,
  input  logic [LANES*N-1:0]           in_i,
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*N-1:0]           out_r,
  output logic [LANES*N-1:0]           out_i,
  output logic [TAG_W-1:0]             out_tag,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int W  = LANES * N;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]     sc_r;
  logic [W-1:0]     sc_i;
  logic [W-1:0]     mem_r [DEPTH];
  logic [W-1:0]     mem_i [DEPTH];
  logic [TAG_W-1:0] mem_t [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             vld;
  logic             push;
  logic             pop;

  fft_lane_scale #(.N(N), .LANES(LANES)) u_scale (
    .scale (in_scale),
    .in_r  (in_r),
    .in_i  (in_i),
    .out_r (sc_r),
    .out_i (sc_i)
  );

  // Ready depends only on registered occupancy and rst, never on out_ready.
  assign in_ready = (cnt < CW'(DEPTH)) & ~rst;
  assign push     = in_valid & in_ready;
  assign pop      = vld & out_ready;

  always_comb begin
    // NOTE: default assignment first so every path drives cnt_nxt and no latch is inferred.
    cnt_nxt = cnt;
    if (push && !pop)      cnt_nxt = cnt + 1'b1;
    else if (pop && !push) cnt_nxt = cnt - 1'b1;
  end

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] adv(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the buffer is reset too, so the head outputs read all-zero after reset.
      for (int e = 0; e < DEPTH; e++) begin
        mem_r[e] <= '0;
        mem_i[e] <= '0;
        mem_t[e] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      vld    <= 1'b0;
    end else if (flush) begin
      // Occupancy only; stale entries are harmless once the pointers restart.
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      vld    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (push) begin
        mem_r[wr_ptr] <= sc_r;
        mem_i[wr_ptr] <= sc_i;
        mem_t[wr_ptr] <= in_tag;
        wr_ptr        <= adv(wr_ptr);
      end
      if (pop) rd_ptr <= adv(rd_ptr);
      cnt <= cnt_nxt;
      vld <= (cnt_nxt != '0);
    end
  end

  assign out_valid = vld;
  assign out_r     = mem_r[rd_ptr];
  assign out_i     = mem_i[rd_ptr];
  assign out_tag   = mem_t[rd_ptr];
  assign count     = cnt;

endmodule

// File: tb/tb_fft_pipe_stage_elastic.sv
// Self-checking bench: directed/table tests on a DEPTH=2 full-width stage and
// randomized scoreboard runs on narrow stages with DEPTH 1, 2, 3 and 5.
module tb_fft_pipe_stage_elastic;

  localparam int N     = 16;
  localparam int LANES = 16;
  localparam int W     = N * LANES;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, flush, in_valid, in_ready, in_scale, out_valid, out_ready;
  logic [W-1:0]     in_r, in_i, out_r, out_i;
  logic [3:0]       in_tag, out_tag;
  logic [1:0]       count;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  fft_pipe_stage_elastic #(.N(N), .LANES(LANES), .DEPTH(DEPTH), .TAG_W(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_scale  (in_scale),
    .in_r      (in_r),
    .in_i      (in_i),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_i     (out_i),
    .out_tag   (out_tag),
    .count     (count)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference halving: floor((x + 1) / 2) in plain integer arithmetic.
  function automatic logic [15:0] half_ref(input logic [15:0] x);
    int v;
    int t;
    v = int'($signed(x));
    t = v + 1;
    if (t >= 0) v = t / 2;
    else        v = -((1 - t) / 2);
    return v[15:0];
  endfunction

  // Beat whose lane k holds seed*16 + k (real) and its negation (imag).
  function automatic logic [W-1:0] mk_lanes(input int seed, input bit neg);
    logic [W-1:0] b;
    int v;
    for (int k = 0; k < LANES; k++) begin
      v = seed * 16 + k;
      if (neg) v = -v;
      b[k*N +: N] = v[15:0];
    end
    return b;
  endfunction

  typedef struct {
    logic        scale;
    logic [15:0] x;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [63:0] r;
    logic [63:0] i;
    logic [3:0]  tag;
  } beat_t;

  // ---------------- randomized scoreboard runs ----------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_rand
    localparam int D   = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 3 : 5;
    localparam int CWG = $clog2(D + 1);

    logic            rrst, rfl, rv, rrdy, rsc, rov, rr;
    logic [63:0]     rir, rii, ror, roi;
    logic [3:0]      rti, rto;
    logic [CWG-1:0]  rcnt;

    fft_pipe_stage_elastic #(.N(16), .LANES(4), .DEPTH(D), .TAG_W(4)) u_rdut (
      .clk       (clk),
      .rst       (rrst),
      .flush     (rfl),
      .in_valid  (rv),
      .in_ready  (rrdy),
      .in_scale  (rsc),
      .in_r      (rir),
      .in_i      (rii),
      .in_tag    (rti),
      .out_valid (rov),
      .out_ready (rr),
      .out_r     (ror),
      .out_i     (roi),
      .out_tag   (rto),
      .count     (rcnt)
    );

    initial begin
      beat_t q[$];
      beat_t nb;
      bit    pend;
      bit    do_push, do_pop;
      int    npop;
      pend = 0;
      npop = 0;
      rrst = 1'b1; rfl = 1'b0; rv = 1'b0; rr = 1'b0; rsc = 1'b0;
      rir = '0; rii = '0; rti = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rrst = 1'b0;
      for (int c = 0; c < 10000; c++) begin
        @(negedge clk);
        check($sformatf("rand_d%0d_valid", D), rov, q.size() != 0);
        check($sformatf("rand_d%0d_count", D), rcnt, q.size());
        check($sformatf("rand_d%0d_ready", D), rrdy, q.size() < D);
        if (q.size() > 0) begin
          check($sformatf("rand_d%0d_r", D), ror, q[0].r);
          check($sformatf("rand_d%0d_i", D), roi, q[0].i);
          check($sformatf("rand_d%0d_tag", D), rto, q[0].tag);
        end
        if (c >= 9961 && rov && rr) npop++;
        if (!pend) begin
          rv = (c >= 9960) ? 1'b1 : (($urandom % 4) != 0);
          rir = {$urandom, $urandom};
          rii = {$urandom, $urandom};
          rti = 4'($urandom);
          rsc = 1'($urandom);
        end
        rr = (c >= 9960) ? 1'b1 : (($urandom % 3) != 0);
        do_push = rv && (q.size() < D);
        do_pop  = (q.size() > 0) && rr;
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
          for (int k = 0; k < 4; k++) begin
            nb.r[k*16 +: 16] = rsc ? half_ref(rir[k*16 +: 16]) : rir[k*16 +: 16];
            nb.i[k*16 +: 16] = rsc ? half_ref(rii[k*16 +: 16]) : rii[k*16 +: 16];
          end
          nb.tag = rti;
          q.push_back(nb);
        end
        pend = rv && !do_push;
      end
      if (D >= 2) check($sformatf("rand_d%0d_tput", D), npop, 39);
      else        check("rand_d1_tput", (npop >= 19 && npop <= 20), 1'b1);
      rv = 1'b0;
      done_cnt++;
    end
  end

  // ---------------- directed tests ----------------
  vec_t         tbl[10];
  logic [W-1:0] er, ei, vr;

  initial begin
    tbl[0] = '{1'b1, 16'h7fff, 16'h4000};
    tbl[1] = '{1'b1, 16'h0003, 16'h0002};
    tbl[2] = '{1'b1, 16'h0001, 16'h0001};
    tbl[3] = '{1'b1, 16'hffff, 16'h0000};
    tbl[4] = '{1'b1, 16'hfffd, 16'hffff};
    tbl[5] = '{1'b1, 16'h8000, 16'hc000};
    tbl[6] = '{1'b1, 16'hfffe, 16'hffff};
    tbl[7] = '{1'b0, 16'h0003, 16'h0003};
    tbl[8] = '{1'b0, 16'h8000, 16'h8000};
    tbl[9] = '{1'b0, 16'hffff, 16'hffff};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_scale = 1'b0; out_ready = 1'b0;
    in_r = '0; in_i = '0; in_tag = '0;
    #1;
    check("rst_in_ready_low", in_ready, 1'b0);
    step();
    step();
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_r", out_r, 0);
    check("rst_out_i", out_i, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_in_ready_held", in_ready, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);

    // 1. continuous stream
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_r = mk_lanes(0, 0);
    in_i = mk_lanes(0, 1);
    in_tag = 4'd0;
    for (int j = 0; j < 8; j++) begin
      step();
      check("stream_valid", out_valid, 1'b1);
      check("stream_tag", out_tag, j);
      check("stream_r", out_r, mk_lanes(0, 0));
      check("stream_i", out_i, mk_lanes(0, 1));
      check("stream_count", count, 1);
      in_tag = 4'(j + 1);
    end
    in_valid = 1'b0;
    step();
    check("stream_drain_valid", out_valid, 1'b0);
    check("stream_drain_count", count, 0);

    // 2. backpressure with three beats
    out_ready = 1'b0;
    in_valid = 1'b1; in_r = mk_lanes(1, 0); in_i = mk_lanes(1, 1); in_tag = 4'ha;
    step();
    check("bp_count1", count, 1);
    in_r = mk_lanes(2, 0); in_i = mk_lanes(2, 1); in_tag = 4'hb;
    step();
    check("bp_count2", count, 2);
    in_r = mk_lanes(3, 0); in_i = mk_lanes(3, 1); in_tag = 4'hc;
    step();
    check("bp_full_count", count, 2);
    check("bp_full_ready", in_ready, 1'b0);
    check("bp_head_tag", out_tag, 4'ha);
    step();
    check("bp_stable_tag", out_tag, 4'ha);
    check("bp_stable_r", out_r, mk_lanes(1, 0));
    check("bp_stable_i", out_i, mk_lanes(1, 1));
    out_ready = 1'b1;
    step();
    check("bp_pop_a_tag", out_tag, 4'hb);
    check("bp_pop_a_r", out_r, mk_lanes(2, 0));
    check("bp_pop_a_count", count, 1);
    step();
    check("bp_pop_b_tag", out_tag, 4'hc);
    check("bp_pop_b_r", out_r, mk_lanes(3, 0));
    check("bp_pop_b_count", count, 1);
    in_valid = 1'b0;
    step();
    check("bp_empty", out_valid, 1'b0);

    // 3. scaling table, one beat per record through an empty stage
    for (int v = 0; v < 10; v++) begin
      in_valid = 1'b1;
      in_scale = tbl[v].scale;
      in_r = {LANES{tbl[v].x}};
      in_i = {LANES{tbl[v].x}};
      in_tag = 4'(v);
      step();
      in_valid = 1'b0;
      check($sformatf("scale_tbl%0d_valid", v), out_valid, 1'b1);
      check($sformatf("scale_tbl%0d_r", v), out_r, {LANES{tbl[v].exp}});
      check($sformatf("scale_tbl%0d_i", v), out_i, {LANES{tbl[v].exp}});
      step();
    end

    // lane-varied scaled beat followed by an unscaled beat of the same data
    for (int k = 0; k < LANES; k++) begin
      vr[k*N +: N] = (k < 6) ? tbl[k].x : 16'h0005;
      er[k*N +: N] = (k < 6) ? tbl[k].exp : 16'h0003;
    end
    ei = er;
    in_valid = 1'b1; in_scale = 1'b1; in_r = vr; in_i = vr; in_tag = 4'h5;
    step();
    check("scale_lanes_r", out_r, er);
    check("scale_lanes_i", out_i, ei);
    in_scale = 1'b0; in_tag = 4'h6;
    step();
    in_valid = 1'b0;
    check("noscale_lanes_r", out_r, vr);
    check("noscale_lanes_tag", out_tag, 4'h6);
    step();

    // 5. flush with a full stage, then with an accepted push in the same cycle
    out_ready = 1'b0;
    in_valid = 1'b1; in_r = mk_lanes(4, 0); in_i = mk_lanes(4, 1); in_tag = 4'h1;
    step();
    in_tag = 4'h2;
    step();
    check("flush_pre_count", count, 2);
    in_tag = 4'h3; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_count", count, 0);
    check("flush_valid", out_valid, 1'b0);
    check("flush_ready", in_ready, 1'b1);
    in_valid = 1'b1; in_tag = 4'h4;
    step();
    check("flush2_pre_count", count, 1);
    in_tag = 4'h5; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush2_count", count, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("flush_no_ghost", out_valid, 1'b0);
    end
    in_valid = 1'b1; in_r = mk_lanes(5, 0); in_i = mk_lanes(5, 1); in_tag = 4'h6;
    step();
    in_valid = 1'b0;
    check("post_flush_tag", out_tag, 4'h6);
    check("post_flush_r", out_r, mk_lanes(5, 0));
    step();

    // 6. reset while full and stalled
    out_ready = 1'b0;
    in_valid = 1'b1; in_r = mk_lanes(6, 0); in_i = mk_lanes(6, 1); in_tag = 4'h7;
    step();
    step();
    in_valid = 1'b0;
    check("rstmid_pre_count", count, 2);
    rst = 1'b1;
    #1;
    check("rstmid_ready_low", in_ready, 1'b0);
    step();
    check("rstmid_valid", out_valid, 1'b0);
    check("rstmid_r", out_r, 0);
    check("rstmid_i", out_i, 0);
    check("rstmid_tag", out_tag, 0);
    check("rstmid_count", count, 0);
    check("rstmid_ready_still_low", in_ready, 1'b0);
    rst = 1'b0;
    step();
    check("rstmid_ready_after", in_ready, 1'b1);

    for (int c = 0; c < 12000 && done_cnt < 4; c++) step();
    check("rand_done", done_cnt, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_pipe_stage_elastic.md
Name: fft_pipe_stage_elastic

Overview:
Parametrised elastic register stage placed between FFT butterfly ranks.
- Carries LANES complex samples (real/imag, N bits each) plus a TAG_W sideband tag as one beat.
- Uses a valid/ready handshake backed by a DEPTH-entry buffer, so a downstream stall never drops data.
- An optional per-beat divide-by-2 with round-half-up gives block scaling between ranks.

Parameters:
N, 16, bit width of each real/imag component (signed, two's complement), N>=4
LANES, 16, complex samples per beat
DEPTH, 2, buffer entries; DEPTH>=2 gives full throughput, DEPTH=1 is legal at 50% throughput
TAG_W, 4, sideband tag width (frame index / sof flags), passed unmodified

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  synchronous clear of occupancy; lower priority than rst
in_valid  in  1  beat offered
in_ready  out  1  stage can accept a beat this cycle
in_scale  in  1  scale this beat by 1/2 (sampled with the beat)
in_r  in  LANES*N  real parts; lane k at [k*N +: N]
in_i  in  LANES*N  imag parts; same packing
in_tag  in  TAG_W  sideband tag
out_valid  out  1  head beat available
out_ready  in  1  downstream accepts head beat
out_r  out  LANES*N  head real parts
out_i  out  LANES*N  head imag parts
out_tag  out  TAG_W  head tag
count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset values:
  - After a rst edge: count=0, out_valid=0, out_r=0, out_i=0, out_tag=0, all buffer entries 0, pointers 0.
  - in_ready is forced 0 while rst=1.
- Push, pop and ready:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready = (count < DEPTH) & !rst. It is driven from registered state only, with no combinational path from out_ready.
  - out_valid = (count != 0), registered. out_r/out_i/out_tag = entry[rd_ptr] from registers.
- Latency:
  - A beat pushed at edge k shows out_valid=1 and its data in the cycle after edge k, if the buffer was empty.
  - Otherwise it appears in FIFO order.
- Simultaneous push and pop:
  - count is unchanged, both pointers advance.
  - Allowed whenever count<DEPTH.
  - When count==DEPTH there is no push (in_ready=0), so a pop-only cycle occurs.
- Pointers: wr_ptr and rd_ptr wrap DEPTH-1 -> 0. DEPTH need not be a power of 2.
- Scaling (in_scale=1), applied per component at push time:
  - y = (x + 1) >>> 1, computed in N+1 bits then truncated to N bits. No overflow is possible.
  - Examples for N=16: 32767->16384, 3->2, 1->1, -1->0, -3->-1, -32768->-16384.
  - When in_scale=0, data is stored unmodified. in_tag is never modified.
- Flush:
  - count=0 and pointers=0 next edge; an in-flight push in the same cycle is discarded.
  - Buffer data is not cleared.
  - rst dominates flush.
- Invalid output and stability:
  - out_r/out_i/out_tag are don't-care while out_valid=0, except the all-zero state after reset.
  - The bench checks data only when out_valid=1.
  - While out_valid=1 and out_ready=0, outputs stay stable.
- Protocol assumption: in_valid must not be withdrawn before acceptance. This is not checked in RTL.
- Reset mid-operation: all beats are lost and the state matches the post-reset state above. No partial output.

Decomposition:
- Shared package fft_pkg:
  - default N and LANES;
  - cplx lane slice helper function (lane k extraction from a flat bus);
  - round-half-up shift function used by the scaler.
- One sub-module, fft_lane_scale: combinational, LANES x 2 components, in_scale gated.
- The top holds the buffer, pointers, count and handshake. Expected size 150-250 lines.

Test Plan:
1. Reset then stream: rst 2 cycles; then in_valid=1 continuously with lane k real=k, imag=-k, tag=incrementing, out_ready=1 -> out_valid rises one cycle after first push, one beat per cycle, values in order, count stays 1.
2. Backpressure (DEPTH=2): out_ready=0, push 3 beats A,B,C -> A and B accepted, count=2, in_ready=0 while C is held. Then out_ready=1 -> A, B, C delivered in order with no loss or duplication, and outputs stable while stalled.
3. Scaling: in_scale=1 with lanes {32767, 3, 1, -1, -3, -32768} on real and imag -> out {16384, 2, 1, 0, -1, -16384}. A following beat with in_scale=0 passes through unchanged.
4. Random stall: random in_valid and out_ready over 10k cycles for DEPTH in {1,2,3,5} -> scoreboard matches in order. DEPTH>=2 with out_ready=1 sustains 1 beat/cycle; DEPTH=1 sustains 1 beat/2 cycles.
5. Flush with push: count=2 plus a push in the same cycle as flush=1 -> next cycle count=0, out_valid=0, in_ready=1. The flushed beats never appear.
6. Reset mid-stream: assert rst while count=DEPTH and out_ready=0 -> next cycle out_valid=0, outputs=0, in_ready=0 during rst, in_ready=1 the cycle after rst deasserts.
